// File: rtl/opb_regbank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : opb_regbank_pkg                                            |
// | Brief   : Shared constants, FSM states and lane mapping for regbank. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package opb_regbank_pkg;

  localparam int OPB_DWIDTH = 32;
  localparam int BYTES      = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  // OPB numbers lanes from the MSB: BE[0] carries register bits 31:24.
  function automatic int be_lane_to_byte(input int lane);
    return BYTES - 1 - lane;
  endfunction

endpackage
`default_nettype wire

// File: rtl/opb_reg_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : opb_reg_slice                                              |
// | Brief   : One 32-bit byte-enabled register with reset value.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module opb_reg_slice
  import opb_regbank_pkg::*;
#(
  parameter logic [OPB_DWIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [BYTES-1:0]      i_be,
  input  logic [OPB_DWIDTH-1:0] i_wdata,
  output logic [OPB_DWIDTH-1:0] o_q
);

  logic [OPB_DWIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else if (i_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_be[b]) r_q[8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/opb_register_bank_ppc2simulink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : opb_register_bank_ppc2simulink                             |
// | Brief   : OPB slave with NUM_REGS software registers and write       |
// |           strobes; OPB_REGBANK_SHADOW_COMMIT_EN adds shadow/commit.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01008000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010080FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          NUM_REGS     = 4,
  parameter logic [31:0] RESET_VAL    = 32'h00000000
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]  OPB_ABus,
  input  logic [0:BYTES-1]         OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]  OPB_DBus,
  input  logic                     OPB_RNW,
  input  logic                     OPB_select,
  input  logic                     OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]  Sl_DBus,
  output logic                     Sl_xferAck,
  output logic                     Sl_errAck,
  output logic                     Sl_retry,
  output logic                     Sl_toutSup,
  output logic [NUM_REGS*32-1:0]   user_data_out,
  output logic [NUM_REGS-1:0]      user_wr_stb
);

`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
  localparam int NWORDS = NUM_REGS + 1;
`else
  localparam int NWORDS = NUM_REGS;
`endif
  localparam int IDXW = $clog2(NUM_REGS + 2);

  state_t                r_state, w_next_state;
  logic                  w_take;
  logic [31:0]           w_addr, w_off;
  logic [29:0]           w_word;
  logic                  w_hit, w_valid;
  logic [IDXW-1:0]       w_idx;
  logic [OPB_DWIDTH-1:0] w_wdata, w_rdata;
  logic [BYTES-1:0]      w_be;
  logic [NUM_REGS-1:0]   w_we, w_stb_next;
  logic [OPB_DWIDTH-1:0] w_q [NUM_REGS];
  logic                  r_ack, r_err;
  logic [OPB_DWIDTH-1:0] r_dbus;
  logic [NUM_REGS-1:0]   r_stb;
  logic                  w_unused;

  assign w_addr  = 32'(OPB_ABus);
  assign w_wdata = OPB_DBus;
  assign w_hit   = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
  assign w_off   = w_addr - C_BASEADDR;
  assign w_word  = w_off[31:2];
  assign w_valid = (w_word < 30'(NWORDS));
  assign w_idx   = w_word[IDXW-1:0];
  assign w_unused = ^{OPB_seqAddr, w_off[1:0], w_word};

  always_comb begin
    w_be = '0;
    for (int l = 0; l < BYTES; l++) w_be[be_lane_to_byte(l)] = OPB_BE[l];
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // A select still held in ACK is deliberately ignored to avoid a double ack.
  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    case (r_state)
      IDLE: if (w_hit) begin
        w_next_state = ACK;
        w_take       = 1'b1;
      end
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    w_we    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDXW'(i)) w_rdata = w_q[i];
      w_we[i] = w_take && w_valid && !OPB_RNW && (w_idx == IDXW'(i));
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_slice
      opb_reg_slice #(.RESET_VAL(RESET_VAL)) u_slice (
        .clk     (OPB_Clk),
        .rst     (OPB_Rst),
        .i_we    (w_we[i]),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .o_q     (w_q[i])
      );
    end
  endgenerate

`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
  logic                  w_commit;
  logic [OPB_DWIDTH-1:0] r_live [NUM_REGS];

  assign w_commit = w_take && w_valid && !OPB_RNW &&
                    (w_idx == IDXW'(NUM_REGS)) && w_wdata[0];

  always_comb begin
    w_stb_next = '0;
    for (int i = 0; i < NUM_REGS; i++) w_stb_next[i] = w_commit && (w_q[i] != r_live[i]);
  end

  always_ff @(posedge OPB_Clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (OPB_Rst)       r_live[i] <= RESET_VAL;
      else if (w_commit) r_live[i] <= w_q[i];
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
      assign user_data_out[32*i +: 32] = r_live[i];
    end
  endgenerate
`else
  assign w_stb_next = w_we;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
      assign user_data_out[32*i +: 32] = w_q[i];
    end
  endgenerate
`endif

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_dbus <= '0;
      r_stb  <= '0;
    end else begin
      r_ack  <= w_take && w_valid;
      r_err  <= w_take && !w_valid;
      r_dbus <= (w_take && w_valid && OPB_RNW) ? w_rdata : '0;
      r_stb  <= w_stb_next;
    end
  end

  assign Sl_DBus     = r_dbus;
  assign Sl_xferAck  = r_ack;
  assign Sl_errAck   = r_err;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_wr_stb = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_opb_register_bank_ppc2simulink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_opb_register_bank_ppc2simulink                          |
// | Brief   : Directed self-checking bench for the OPB register bank.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_opb_register_bank_ppc2simulink;

`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
  localparam bit          SH       = 1'b1;
  localparam logic [31:0] ERR_ADDR = 32'h01008014;
`else
  localparam bit          SH       = 1'b0;
  localparam logic [31:0] ERR_ADDR = 32'h01008010;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [0:31]  abus;
  logic [0:3]   be;
  logic [0:31]  dbus;
  logic         rnw, sel, seq;
  logic [0:31]  sl_dbus;
  logic         xack, eack, retry, tout;
  logic [127:0] ud;
  logic [3:0]   stb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
    .Sl_xferAck(xack), .Sl_errAck(eack), .Sl_retry(retry), .Sl_toutSup(tout),
    .user_data_out(ud), .user_wr_stb(stb)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transfer: drive at negedge, inspect the ack cycle, then the cycle after.
  task automatic bus_xfer(input string tag, input logic [31:0] addr, input logic r,
                          input logic [0:3] b, input logic [31:0] wd,
                          input logic ea, input logic ee, input logic [31:0] erd,
                          input logic [3:0] es);
    @(negedge clk);
    abus = addr; rnw = r; be = b; dbus = wd; sel = 1'b1;
    check({tag, ":pre_ack"}, 128'(xack), 128'(0));
    @(posedge clk); #1;
    check({tag, ":ack"}, 128'(xack), 128'(ea));
    check({tag, ":err"}, 128'(eack), 128'(ee));
    check({tag, ":dbus"}, 128'(sl_dbus), 128'(erd));
    check({tag, ":stb"}, 128'(stb), 128'(es));
    sel = 1'b0;
    @(posedge clk); #1;
    check({tag, ":post"}, {xack, eack, stb, sl_dbus}, '0);
  endtask

  initial begin
    int acks;
    rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {xack, eack, retry, tout, stb, sl_dbus}, '0);
    check("reset_ud", ud, '0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 4; i++)
      bus_xfer($sformatf("rd_reset%0d", i), 32'h01008000 + 32'(4*i), 1'b1, 4'b1111, 32'h0,
               1'b1, 1'b0, 32'h0, 4'b0000);

    bus_xfer("wr_full", 32'h01008004, 1'b0, 4'b1111, 32'hDEADBEEF,
             1'b1, 1'b0, 32'h0, SH ? 4'b0000 : 4'b0010);
`ifndef OPB_REGBANK_SHADOW_COMMIT_EN
    check("ud_full", ud, 128'h00000000_00000000_DEADBEEF_00000000);
`endif
    bus_xfer("rb_full", 32'h01008004, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 4'b0000);

    bus_xfer("wr_be0101", 32'h01008004, 1'b0, 4'b0101, 32'h11223344,
             1'b1, 1'b0, 32'h0, SH ? 4'b0000 : 4'b0010);
    bus_xfer("rb_be0101", 32'h01008006, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, 32'hDE22BE44, 4'b0000);

    bus_xfer("err_wr", ERR_ADDR, 1'b0, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0, 4'b0000);
    bus_xfer("err_rd", ERR_ADDR, 1'b1, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h0, 4'b0000);
    bus_xfer("after_err", 32'h01008004, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, 32'hDE22BE44, 4'b0000);

    // Select held for six cycles: acks on alternate cycles only.
    @(negedge clk);
    abus = 32'h01008004; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (xack) acks++;
      check($sformatf("hold_ack%0d", c), 128'(xack), 128'((c % 2) == 0));
      check($sformatf("hold_dbus%0d", c), 128'(sl_dbus), (c % 2) == 0 ? 128'h DE22BE44 : 128'h0);
    end
    sel = 1'b0;
    check("hold_count", 128'(acks), 128'(3));

    bus_xfer("wr_be0000", 32'h0100800C, 1'b0, 4'b0000, 32'hFFFFFFFF,
             1'b1, 1'b0, 32'h0, SH ? 4'b0000 : 4'b1000);
    bus_xfer("rb_be0000", 32'h0100800C, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, 32'h0, 4'b0000);
    bus_xfer("wr_be1000", 32'h01008000, 1'b0, 4'b1000, 32'hAABBCCDD,
             1'b1, 1'b0, 32'h0, SH ? 4'b0000 : 4'b0001);
    bus_xfer("wr_idx2", 32'h01008008, 1'b0, 4'b1111, 32'h12345678,
             1'b1, 1'b0, 32'h0, SH ? 4'b0000 : 4'b0100);
`ifndef OPB_REGBANK_SHADOW_COMMIT_EN
    check("ud_mix", ud, 128'h00000000_12345678_DE22BE44_AA000000);
`endif

    bus_xfer("oow_high", 32'h01008100, 1'b1, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h0, 4'b0000);
    bus_xfer("oow_low", 32'h01007FFC, 1'b0, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 4'b0000);
    bus_xfer("rb_idx0", 32'h01008000, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, 32'hAA000000, 4'b0000);

    // Reset asserted in the hit cycle of a write to idx 2.
    @(negedge clk);
    abus = 32'h01008008; rnw = 1'b0; be = 4'b1111; dbus = 32'hCAFEF00D; sel = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_outs", {xack, eack, stb, sl_dbus}, '0);
    check("rstmid_ud", ud, '0);
    @(negedge clk); rst = 1'b0; sel = 1'b0;
    bus_xfer("rstmid_rb", 32'h01008008, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, RESET_VAL_TB(), 4'b0000);

`ifdef OPB_REGBANK_SHADOW_COMMIT_EN
    bus_xfer("sh_wr", 32'h01008000, 1'b0, 4'b1111, 32'h00000005, 1'b1, 1'b0, 32'h0, 4'b0000);
    check("sh_precommit", ud[31:0], 128'h0);
    bus_xfer("sh_rb", 32'h01008000, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, 32'h00000005, 4'b0000);
    bus_xfer("sh_commit", 32'h01008010, 1'b0, 4'b1111, 32'h00000001, 1'b1, 1'b0, 32'h0, 4'b0001);
    check("sh_postcommit", ud, 128'h5);
    bus_xfer("sh_commit_rd", 32'h01008010, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b0, 32'h0, 4'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  function automatic logic [31:0] RESET_VAL_TB();
    return 32'h00000000;
  endfunction

endmodule
`default_nettype wire
